// File: rtl/control_estado_seq.sv
// -----------------------------------------------------------------------------
// control_estado_seq
// -----------------------------------------------------------------------------
// Registered stage sequencer. Holds the current stage (0 = idle,
// 1..N_ESTADOS = active) and advances one stage per rising edge of `avance`
// while `credito` is present. At the last stage it either returns to idle or
// wraps to stage 1, emitting a one-cycle `fin` pulse. It can be cancelled, and
// it falls back to idle after TIMEOUT_CYC cycles in a stage with no advance,
// emitting a one-cycle `timeout` pulse.
//
// Handshake: there is no valid/ready handshake. `avance`, `credito` and
// `cancelar` are plain levels sampled on every rising clock edge. An advance
// is the cycle where `avance` is high after having been low the cycle before.
//
// Ports
//   clk            in  1  system clock, rising edge
//   rst_n          in  1  asynchronous active-low reset
//   avance         in  1  advance request (level, edge detected inside)
//   credito        in  1  credit present; low forces idle
//   cancelar       in  1  synchronous abort to idle
//   estado_actual  out W  current stage, registered (0 = idle)
//   activo         out 1  registered, high when estado_actual != 0
//   fin            out 1  one-cycle pulse when the last stage is advanced past
//   timeout        out 1  one-cycle pulse on inactivity abort
// -----------------------------------------------------------------------------
module control_estado_seq #(
    parameter int N_ESTADOS    = 6,
    parameter int W            = 4,
    parameter int TIMEOUT_CYC  = 1000,
    parameter int MODO_CICLICO = 0,
    parameter int TW           = 16
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         avance,
    input  logic         credito,
    input  logic         cancelar,
    output logic [W-1:0] estado_actual,
    output logic         activo,
    output logic         fin,
    output logic         timeout
);

    localparam logic [W-1:0]  LP_ULTIMO = W'(N_ESTADOS);
    localparam logic [TW-1:0] LP_TO_LIM = TW'(TIMEOUT_CYC - 1);
    localparam bit            LP_TO_EN  = (TIMEOUT_CYC != 0);
    localparam bit            LP_CICLO  = (MODO_CICLICO != 0);

    // Action chosen for this cycle, in priority order. Exposed through the
    // debug-friendly enum so checkers can bind to the decision directly.
    typedef enum logic [2:0] {
        ACC_MANTENER    = 3'd0,
        ACC_CANCELAR    = 3'd1,
        ACC_SIN_CREDITO = 3'd2,
        ACC_FUERA_RANGO = 3'd3,
        ACC_TIMEOUT     = 3'd4,
        ACC_AVANZAR     = 3'd5
    } accion_t;

    logic [W-1:0]  r_estado;
    logic          r_activo;
    logic          r_fin;
    logic          r_timeout;
    logic [TW-1:0] r_cnt;
    logic          r_avance_q;

    logic          w_adv;
    accion_t       w_accion;
    logic [W-1:0]  w_estado_nxt;
    logic [TW-1:0] w_cnt_nxt;
    logic          w_fin_nxt;
    logic          w_timeout_nxt;

    // ------------------------------------------------------------------
    // State register. r_avance_q resets to 1 so that an avance held high
    // through reset is not seen as an edge once reset is released.
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_estado   <= '0;
            r_activo   <= 1'b0;
            r_fin      <= 1'b0;
            r_timeout  <= 1'b0;
            r_cnt      <= '0;
            r_avance_q <= 1'b1;
        end else begin
            r_estado   <= w_estado_nxt;
            r_activo   <= (w_estado_nxt != '0);
            r_fin      <= w_fin_nxt;
            r_timeout  <= w_timeout_nxt;
            r_cnt      <= w_cnt_nxt;
            r_avance_q <= avance;
        end
    end

    // ------------------------------------------------------------------
    // Action select: cancel > no credit > out-of-range > timeout > advance.
    // A timeout only fires on a cycle with no advance, so an edge arriving
    // exactly on the last allowed cycle still advances.
    // ------------------------------------------------------------------
    always_comb begin
        w_adv    = avance & ~r_avance_q;
        w_accion = ACC_MANTENER;
        if (cancelar) begin
            w_accion = ACC_CANCELAR;
        end else if (!credito) begin
            w_accion = ACC_SIN_CREDITO;
        end else if (r_estado > LP_ULTIMO) begin
            w_accion = ACC_FUERA_RANGO;
        end else if (LP_TO_EN && (r_estado != '0) && (r_cnt == LP_TO_LIM) && !w_adv) begin
            w_accion = ACC_TIMEOUT;
        end else if (w_adv) begin
            w_accion = ACC_AVANZAR;
        end
    end

    // ------------------------------------------------------------------
    // Next-state values for the selected action.
    // ------------------------------------------------------------------
    always_comb begin
        w_estado_nxt  = r_estado;
        w_cnt_nxt     = r_cnt;
        w_fin_nxt     = 1'b0;
        w_timeout_nxt = 1'b0;
        case (w_accion)
            ACC_CANCELAR, ACC_SIN_CREDITO, ACC_FUERA_RANGO: begin
                w_estado_nxt = '0;
                w_cnt_nxt    = '0;
            end
            ACC_TIMEOUT: begin
                w_estado_nxt  = '0;
                w_cnt_nxt     = '0;
                w_timeout_nxt = 1'b1;
            end
            ACC_AVANZAR: begin
                w_cnt_nxt = '0;
                if (r_estado == LP_ULTIMO) begin
                    w_fin_nxt    = 1'b1;
                    w_estado_nxt = LP_CICLO ? W'(1) : '0;
                end else begin
                    w_estado_nxt = r_estado + W'(1);
                end
            end
            default: begin
                // Idle keeps the counter at 0; active stages count up and
                // saturate at all-ones instead of wrapping.
                if (r_estado == '0) begin
                    w_cnt_nxt = '0;
                end else if (r_cnt != '1) begin
                    w_cnt_nxt = r_cnt + TW'(1);
                end
            end
        endcase
    end

    assign estado_actual = r_estado;
    assign activo        = r_activo;
    assign fin           = r_fin;
    assign timeout       = r_timeout;

endmodule
